sm2_modmul_iter: RTL and testbench

- Word-serial Montgomery modular multiplier. Computes R = A·B·2^(−NUM_WORDS·WORD_LEN) mod P, fully reduced (R < P).
- Modulus is a run-time input, so the block covers SM2 and any other odd modulus.
- Trades area for latency relative to the full-array 2-stage SM2 multiplier: NUM_WORDS multipliers instead of NUM_WORDS².
- Sits behind the point-arithmetic sequencer and uses a valid/ready handshake on both sides.

---
 rtl/sm2_modmul_pkg.sv | 21 ++
 rtl/sm2_modmul_iter_mont_word_mac.sv | 24 ++
 rtl/sm2_modmul_iter.sv | 143 ++++++++++++++
 tb/tb_sm2_modmul_iter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm2_modmul_pkg.sv
// Shared types and SM2 constants for the word-serial Montgomery multiplier.
package sm2_modmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_RED   = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [255:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  // Low 32 bits of SM2_P are all ones, so -P^-1 is 1 for any word width up to 32.
  localparam logic [31:0] SM2_N0_INV = 32'd1;

  localparam logic [255:0] SM2_R_MOD_P =
    256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;

endpackage

// File: rtl/sm2_modmul_iter_mont_word_mac.sv
// Combinational T + X*y built from one word product per word of X.
module mont_word_mac #(
  parameter int NUM_WORDS = 16,
  parameter int WORD_LEN  = 16,
  parameter int OP_W      = NUM_WORDS * WORD_LEN,
  parameter int ACC_W     = OP_W + WORD_LEN + 2
) (
  input  logic [ACC_W-1:0]    t,
  input  logic [OP_W-1:0]     x,
  input  logic [WORD_LEN-1:0] y,
  output logic [ACC_W-1:0]    sum
);

  // Sum the shifted word products into a single accumulator.
  always_comb begin
    sum = t;
    for (int j = 0; j < NUM_WORDS; j++) begin
      logic [2*WORD_LEN-1:0] prod;
      prod = {{WORD_LEN{1'b0}}, x[j*WORD_LEN +: WORD_LEN]} * {{WORD_LEN{1'b0}}, y};
      sum  = sum + (ACC_W'(prod) << (j * WORD_LEN));
    end
  end

endmodule

// File: rtl/sm2_modmul_iter.sv
// Word-serial Montgomery multiplier: R = A*B*2^-(NUM_WORDS*WORD_LEN) mod P, fully reduced.
module sm2_modmul_iter
  import sm2_modmul_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter int WORD_LEN  = 16,
  parameter int TAG_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_WORDS*WORD_LEN-1:0] in_a,
  input  logic [NUM_WORDS*WORD_LEN-1:0] in_b,
  input  logic [NUM_WORDS*WORD_LEN-1:0] in_p,
  input  logic [WORD_LEN-1:0]           in_n0_inv,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_WORDS*WORD_LEN-1:0] out_r,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          busy
);

  localparam int OP_W  = NUM_WORDS * WORD_LEN;
  localparam int T_W   = OP_W + 2;
  localparam int ACC_W = OP_W + WORD_LEN + 2;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_t               state;
  logic [OP_W-1:0]      a_r;
  logic [OP_W-1:0]      b_r;
  logic [OP_W-1:0]      p_r;
  logic [WORD_LEN-1:0]  n0_r;
  logic [TAG_W-1:0]     tag_r;
  logic [T_W-1:0]       t_r;
  logic [ACC_W-1:0]     acc_r;
  logic [CNT_W-1:0]     cnt_r;

  logic [WORD_LEN-1:0]  q;
  logic [ACC_W-1:0]     mac_t;
  logic [OP_W-1:0]      mac_x;
  logic [WORD_LEN-1:0]  mac_y;
  logic [ACC_W-1:0]     mac_sum;
  logic [T_W-1:0]       t_sub;

  assign in_ready = (state == S_IDLE);

  // Share the single word MAC between a*b[i] and q*p, and form the final subtract.
  always_comb begin
    q     = acc_r[WORD_LEN-1:0] * n0_r;
    t_sub = t_r - {2'b00, p_r};
    if (state == S_RED) begin
      mac_t = acc_r;
      mac_x = p_r;
      mac_y = q;
    end else begin
      mac_t = ACC_W'(t_r);
      mac_x = a_r;
      mac_y = b_r[WORD_LEN-1:0];
    end
  end

  mont_word_mac #(
    .NUM_WORDS (NUM_WORDS),
    .WORD_LEN  (WORD_LEN),
    .OP_W      (OP_W),
    .ACC_W     (ACC_W)
  ) u_mac (
    .t   (mac_t),
    .x   (mac_x),
    .y   (mac_y),
    .sum (mac_sum)
  );

  // Control FSM with registered datapath and outputs; b_r shifts so word i sits at the bottom.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_tag   <= '0;
      busy      <= 1'b0;
      cnt_r     <= '0;
      t_r       <= '0;
      acc_r     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      p_r       <= '0;
      n0_r      <= '0;
      tag_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r   <= in_a;
            b_r   <= in_b;
            p_r   <= in_p;
            n0_r  <= in_n0_inv;
            tag_r <= in_tag;
            t_r   <= '0;
            cnt_r <= '0;
            busy  <= 1'b1;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc_r <= mac_sum;
          state <= S_RED;
        end
        S_RED: begin
          t_r <= T_W'(mac_sum >> WORD_LEN);
          b_r <= b_r >> WORD_LEN;
          if (cnt_r == CNT_W'(NUM_WORDS - 1)) begin
            state <= S_FINAL;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            state <= S_MAC;
          end
        end
        S_FINAL: begin
          out_r     <= OP_W'((t_r >= {2'b00, p_r}) ? t_sub : t_r);
          out_tag   <= tag_r;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm2_modmul_iter.sv
// Self-checking bench: default 256-bit instance plus a 2x8-bit instance for random sweeps.
module tb_sm2_modmul_iter;
  import sm2_modmul_pkg::*;

  localparam int OW  = 256;
  localparam int WL  = 16;
  localparam int SOW = 16;
  localparam int SWL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [OW-1:0]  b_a, b_b, b_p, b_out_r;
  logic [WL-1:0]  b_n0;
  logic [3:0]     b_tag, b_out_tag;

  logic           s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [SOW-1:0] s_a, s_b, s_p, s_out_r;
  logic [SWL-1:0] s_n0;
  logic [3:0]     s_tag, s_out_tag;

  sm2_modmul_iter u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_a), .in_b(b_b), .in_p(b_p), .in_n0_inv(b_n0), .in_tag(b_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_r(b_out_r),
    .out_tag(b_out_tag), .busy(b_busy)
  );

  sm2_modmul_iter #(.NUM_WORDS(2), .WORD_LEN(8), .TAG_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_a), .in_b(s_b), .in_p(s_p), .in_n0_inv(s_n0), .in_tag(s_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_r(s_out_r),
    .out_tag(s_out_tag), .busy(s_busy)
  );

  typedef struct {
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic [3:0]    tag;
    logic [OW-1:0] r;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: reduce A*B mod P, then divide by 2 once per operand bit modulo P.
  function automatic logic [OW-1:0] ref_big(input logic [OW-1:0] a, b, p);
    logic [2*OW-1:0] x;
    x = ({256'd0, a} * {256'd0, b}) % {256'd0, p};
    for (int k = 0; k < OW; k++) x = x[0] ? ((x + {256'd0, p}) >> 1) : (x >> 1);
    return x[OW-1:0];
  endfunction

  function automatic logic [SOW-1:0] ref_small(input logic [SOW-1:0] a, b, p);
    logic [32:0] x;
    x = ({17'd0, a} * {17'd0, b}) % {17'd0, p};
    for (int k = 0; k < SOW; k++) x = x[0] ? ((x + {17'd0, p}) >> 1) : (x >> 1);
    return x[SOW-1:0];
  endfunction

  function automatic logic [OW-1:0] rand_below_p();
    logic [OW-1:0] x;
    for (int k = 0; k < 8; k++) x[k*32 +: 32] = $urandom;
    if (x >= SM2_P) x = x - SM2_P;
    return x;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic big_start(input logic [OW-1:0] a, b, input logic [3:0] tag, output int w);
    w = 0;
    while (!b_in_ready && w < 200) begin @(negedge clk); w++; end
    if (!b_in_ready) begin
      checks++; errors++;
      $display("FAIL big_accept_timeout: in_ready got 0 expected 1");
    end
    b_a = a; b_b = b; b_tag = tag; b_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    b_a = ~a; b_b = ~b; b_tag = ~tag;
  endtask

  task automatic big_wait(output int lat);
    lat = 0;
    while (!b_out_valid && lat < 200) begin @(negedge clk); lat++; end
  endtask

  task automatic big_op(input logic [OW-1:0] a, b, input logic [3:0] tag,
                        output logic [OW-1:0] r, output logic [3:0] tg, output int lat);
    int w;
    big_start(a, b, tag, w);
    big_wait(lat);
    r = b_out_r; tg = b_out_tag;
  endtask

  task automatic small_op(input logic [SOW-1:0] a, b, input logic [3:0] tag,
                          output logic [SOW-1:0] r, output logic [3:0] tg, output int lat);
    int w = 0;
    while (!s_in_ready && w < 100) begin @(negedge clk); w++; end
    s_a = a; s_b = b; s_tag = tag; s_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    s_a = ~a; s_b = ~b; s_tag = ~tag;
    lat = 0;
    while (!s_out_valid && lat < 100) begin @(negedge clk); lat++; end
    r = s_out_r; tg = s_out_tag;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0]  r;
    logic [SOW-1:0] sr, sa, sb;
    logic [3:0]     tg;
    int             lat, w, n;
    bit             acc2;
    int             t_seen[2];
    logic [3:0]     tg_seen[2];
    logic [OW-1:0]  r_seen[2];

    rst_n = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_a = '0; b_b = '0; b_tag = '0;
    b_p = SM2_P; b_n0 = SM2_N0_INV[WL-1:0];
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_tag = '0;
    s_p = 16'hFFF1; s_n0 = 8'hEF;

    vecs[0] = '{SM2_R_MOD_P, 256'd5, 4'd1, 256'd5};
    vecs[1] = '{SM2_R_MOD_P, SM2_P - 256'd1, 4'd2, SM2_P - 256'd1};
    vecs[2] = '{SM2_R_MOD_P, SM2_R_MOD_P, 4'd3, SM2_R_MOD_P};
    vecs[3] = '{256'd0, rand_below_p(), 4'd4, 256'd0};
    for (int i = 4; i < 6; i++) begin
      vecs[i].a = rand_below_p();
      vecs[i].b = rand_below_p();
      vecs[i].tag = 4'(i + 8);
      vecs[i].r = ref_big(vecs[i].a, vecs[i].b, SM2_P);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", OW'(b_out_valid), 256'd0);
    chk("rst_out_r", b_out_r, 256'd0);
    chk("rst_out_tag", OW'(b_out_tag), 256'd0);
    chk("rst_busy", OW'(b_busy), 256'd0);
    chk("rst_in_ready", OW'(b_in_ready), 256'd1);
    chk("rst_small_busy", OW'(s_busy), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      big_op(vecs[i].a, vecs[i].b, vecs[i].tag, r, tg, lat);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_tag", i), OW'(tg), OW'(vecs[i].tag));
      chk($sformatf("vec%0d_latency", i), OW'(lat), 256'd33);
    end

    small_op(16'h000F, 16'd1000, 4'd5, sr, tg, lat);
    chk("small_r_1000", OW'(sr), 256'd1000);
    chk("small_tag", OW'(tg), 256'd5);
    chk("small_latency", OW'(lat), 256'd5);
    for (int i = 0; i < 1000; i++) begin
      sa = 16'($urandom_range(0, 32'hFFF0));
      sb = 16'($urandom_range(0, 32'hFFF0));
      small_op(sa, sb, 4'(i), sr, tg, lat);
      chk($sformatf("sweep%0d_r a=%h b=%h", i, sa, sb), OW'(sr), OW'(ref_small(sa, sb, 16'hFFF1)));
      if (tg !== 4'(i)) chk($sformatf("sweep%0d_tag", i), OW'(tg), OW'(4'(i)));
    end

    // Backpressure: result held, requests ignored while DONE.
    b_out_ready = 1'b0;
    big_op(SM2_R_MOD_P, 256'd9, 4'hA, r, tg, lat);
    chk("bp_r", r, 256'd9);
    for (int k = 0; k < 10; k++) begin
      b_in_valid = (k % 2 == 0); b_a = rand_below_p(); b_tag = 4'(k);
      @(negedge clk);
      chk($sformatf("bp_hold_r%0d", k), b_out_r, 256'd9);
      chk($sformatf("bp_hold_tag%0d", k), OW'(b_out_tag), 256'hA);
      chk($sformatf("bp_in_ready%0d", k), OW'({b_in_ready, b_out_valid}), 256'd1);
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", OW'(b_out_valid), 256'd0);
    chk("bp_release_ready", OW'(b_in_ready), 256'd1);
    big_start(SM2_R_MOD_P, 256'd11, 4'hB, w);
    chk("bp_accept_wait", OW'(w), 256'd0);
    chk("bp_accept_busy", OW'(b_busy), 256'd1);
    big_wait(lat);
    chk("bp_next_r", b_out_r, 256'd11);
    chk("bp_next_latency", OW'(lat), 256'd33);

    // Back-to-back with in_valid held high: tags 3 then 7.
    w = 0;
    @(negedge clk);
    while (!b_in_ready && w < 200) begin @(negedge clk); w++; end
    b_a = SM2_R_MOD_P; b_b = 256'd20; b_tag = 4'd3; b_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_b = 256'd21; b_tag = 4'd7;
    n = 0; acc2 = 1'b0;
    t_seen = '{0, 0}; tg_seen = '{4'd0, 4'd0}; r_seen = '{256'd0, 256'd0};
    for (int k = 0; k < 150 && n < 2; k++) begin
      if (b_out_valid) begin
        t_seen[n] = cyc; tg_seen[n] = b_out_tag; r_seen[n] = b_out_r; n++;
      end
      if (acc2) b_in_valid = 1'b0;
      if (b_in_ready && b_in_valid) acc2 = 1'b1;
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    chk("b2b_count", OW'(n), 256'd2);
    chk("b2b_tag0", OW'(tg_seen[0]), 256'd3);
    chk("b2b_tag1", OW'(tg_seen[1]), 256'd7);
    chk("b2b_r0", r_seen[0], 256'd20);
    chk("b2b_r1", r_seen[1], 256'd21);
    chk("b2b_spacing", OW'(t_seen[1] - t_seen[0]), 256'd35);

    // Reset while in MAC for word 5.
    big_start(SM2_R_MOD_P, 256'd13, 4'h6, w);
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", OW'(b_busy), 256'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", OW'(b_busy), 256'd0);
    chk("mid_rst_valid", OW'(b_out_valid), 256'd0);
    chk("mid_rst_ready", OW'(b_in_ready), 256'd1);
    chk("mid_rst_out_r", b_out_r, 256'd0);
    big_op(SM2_R_MOD_P, 256'd17, 4'h9, r, tg, lat);
    chk("post_rst_r", r, 256'd17);
    chk("post_rst_tag", OW'(tg), 256'd9);
    chk("post_rst_latency", OW'(lat), 256'd33);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
